wb_port_arbiter: RTL and testbench

//  Write-back stage feeding the register file's single write port (Wt_addr/Wt_data/L_S).

---
 rtl/wb_port_arbiter.sv | 112 +++++++++++
 tb/tb_wb_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter for the single register-file write port: ALU results first,
// long-latency completions bypassed or queued, plus a busy scoreboard for decode.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_wb_valid,
  input  logic [4:0]                 alu_wb_addr,
  input  logic [31:0]                alu_wb_data,
  input  logic                       lq_issue_valid,
  input  logic [4:0]                 lq_issue_addr,
  input  logic                       lq_done_valid,
  input  logic [4:0]                 lq_done_addr,
  input  logic [31:0]                lq_done_data,
  output logic                       lq_done_ready,
  output logic                       alu_stall,
  output logic [4:0]                 Wt_addr,
  output logic [31:0]                Wt_data,
  output logic                       L_S,
  output logic [31:0]                busy_mask,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(STARVE_LIMIT) + 1;

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [WW-1:0] wait_cnt, wait_inc;
  logic          fifo_empty, accept, alu_fire, pop, bypass, push;
  logic [31:0]   busy_next;

  assign lq_done_ready = (fifo_count < CW'(DEPTH));
  assign fifo_empty    = (fifo_count == '0);
  assign accept        = lq_done_valid & lq_done_ready;
  assign alu_fire      = !alu_stall & alu_wb_valid & (alu_wb_addr != 5'd0);
  assign pop           = !alu_fire & !fifo_empty;
  assign bypass        = !alu_fire & fifo_empty & accept & (lq_done_addr != 5'd0);
  assign push          = accept & (lq_done_addr != 5'd0) & !bypass;
  assign wait_inc      = wait_cnt + WW'(1);

  // Issue is applied after the completion clear so a same-register set wins.
  always_comb begin
    busy_next = busy_mask;
    if (pop)
      busy_next[mem_addr[rd_ptr]] = 1'b0;
    else if (bypass)
      busy_next[lq_done_addr] = 1'b0;
    if (lq_issue_valid)
      busy_next[lq_issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= lq_done_addr;
      mem_data[wr_ptr] <= lq_done_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      wait_cnt   <= '0;
      alu_stall  <= 1'b0;
      L_S        <= 1'b0;
      Wt_addr    <= '0;
      Wt_data    <= '0;
      busy_mask  <= '0;
    end else begin
      busy_mask <= busy_next;
      L_S       <= alu_fire | pop | bypass;
      if (alu_fire) begin
        Wt_addr <= alu_wb_addr;
        Wt_data <= alu_wb_data;
      end else if (pop) begin
        Wt_addr <= mem_addr[rd_ptr];
        Wt_data <= mem_data[rd_ptr];
      end else if (bypass) begin
        Wt_addr <= lq_done_addr;
        Wt_data <= lq_done_data;
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      // Head waiting without a pop: count up and force a stall once at the limit.
      if (pop) begin
        wait_cnt  <= '0;
        alu_stall <= 1'b0;
      end else if (!fifo_empty) begin
        wait_cnt <= wait_inc;
        if (wait_inc == WW'(STARVE_LIMIT - 1))
          alu_stall <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with an expected-write queue scoreboard.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_addr;
  logic [31:0] alu_wb_data;
  logic        lq_issue_valid;
  logic [4:0]  lq_issue_addr;
  logic        lq_done_valid;
  logic [4:0]  lq_done_addr;
  logic [31:0] lq_done_data;
  logic        lq_done_ready;
  logic        alu_stall;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;
  logic        L_S;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cmp_cnt = 0;
  int  mis_cnt = 0;

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .lq_issue_valid(lq_issue_valid), .lq_issue_addr(lq_issue_addr),
    .lq_done_valid(lq_done_valid), .lq_done_addr(lq_done_addr), .lq_done_data(lq_done_data),
    .lq_done_ready(lq_done_ready), .alu_stall(alu_stall),
    .Wt_addr(Wt_addr), .Wt_data(Wt_data), .L_S(L_S),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then score any register-file write against the queue head.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (L_S === 1'b1) begin
      cmp_cnt++;
      assert (exp_q.size() > 0) else begin
        mis_cnt++;
        $error("FAIL unexpected_write observed=r%0d expected=no write", Wt_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wt_addr", {27'd0, Wt_addr}, {27'd0, e.addr});
        chk("wt_data", Wt_data, e.data);
      end
    end
  endtask

  task automatic idle();
    alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
    lq_issue_valid = 0; lq_issue_addr = 0;
    lq_done_valid = 0; lq_done_addr = 0; lq_done_data = 0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    alu_wb_valid = 1; alu_wb_addr = a; alu_wb_data = d;
  endtask

  task automatic done(input logic [4:0] a, input logic [31:0] d);
    lq_done_valid = 1; lq_done_addr = a; lq_done_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    lq_issue_valid = 1; lq_issue_addr = a;
  endtask

  initial begin
    idle();
    rst = 0;
    repeat (2) step();
    chk("rst_ls", {31'd0, L_S}, 0);
    chk("rst_wt_addr", {27'd0, Wt_addr}, 0);
    chk("rst_wt_data", Wt_data, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", {31'd0, alu_stall}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_ready", {31'd0, lq_done_ready}, 1);
    rst = 1;

    // Bypass
    issue(5); step(); idle();
    chk("byp_busy_set", busy_mask, 32'h0000_0020);
    done(5, 32'hDEADBEEF); exp_q.push_back('{5'd5, 32'hDEADBEEF});
    step(); idle();
    chk("byp_ls", {31'd0, L_S}, 1);
    chk("byp_busy_clr", busy_mask, 0);
    chk("byp_count", {29'd0, fifo_count}, 0);

    // ALU with addr 0 is ignored
    alu(0, 32'h5555); step(); idle();
    chk("alu0_ls", {31'd0, L_S}, 0);

    // Priority: ALU first, queued completion next cycle
    issue(7); step(); idle();
    alu(3, 32'h11); done(7, 32'h22);
    exp_q.push_back('{5'd3, 32'h11}); exp_q.push_back('{5'd7, 32'h22});
    step(); idle();
    chk("pri_ls1", {31'd0, L_S}, 1);
    chk("pri_count1", {29'd0, fifo_count}, 1);
    chk("pri_busy7", busy_mask, 32'h0000_0080);
    step();
    chk("pri_ls2", {31'd0, L_S}, 1);
    chk("pri_count2", {29'd0, fifo_count}, 0);
    chk("pri_busy_clr", busy_mask, 0);
    step();
    chk("pri_idle_ls", {31'd0, L_S}, 0);

    // Full FIFO under continuous ALU traffic, then forced pop
    for (int i = 1; i <= 8; i++) begin
      alu(5'(10 + i), 32'hA000 + i);
      exp_q.push_back('{5'(10 + i), 32'hA000 + i});
      if (i <= 5) done(5'(16 + i), 32'hC000 + i);
      step();
      if (i == 4) begin
        chk("full_count", {29'd0, fifo_count}, 4);
        chk("full_ready", {31'd0, lq_done_ready}, 0);
      end
      if (i == 7) chk("full_stall_pre", {31'd0, alu_stall}, 0);
      if (i == 8) chk("full_stall_set", {31'd0, alu_stall}, 1);
    end
    chk("full_count_held", {29'd0, fifo_count}, 4);
    alu(19, 32'hA009);
    exp_q.push_back('{5'd17, 32'hC001});
    step();
    chk("full_stall_clr", {31'd0, alu_stall}, 0);
    chk("full_count_pop", {29'd0, fifo_count}, 3);
    chk("full_ready_back", {31'd0, lq_done_ready}, 1);
    exp_q.push_back('{5'd19, 32'hA009});
    step(); idle();
    chk("full_c5_pushed", {29'd0, fifo_count}, 4);
    for (int i = 2; i <= 5; i++) exp_q.push_back('{5'(16 + i), 32'hC000 + i});
    repeat (4) step();
    chk("full_drained", {29'd0, fifo_count}, 0);
    step();
    chk("full_idle_ls", {31'd0, L_S}, 0);

    // Starvation with a single queued entry
    issue(12); step(); idle();
    for (int i = 0; i < 8; i++) begin
      alu(1, 32'hB000 + i);
      exp_q.push_back('{5'd1, 32'hB000 + i});
      if (i == 0) done(12, 32'h12);
      step();
      lq_done_valid = 0;
      if (i == 6) chk("stv_stall_pre", {31'd0, alu_stall}, 0);
      if (i == 7) chk("stv_stall_set", {31'd0, alu_stall}, 1);
    end
    chk("stv_busy12", busy_mask, 32'h0000_1000);
    alu(1, 32'hB008);
    exp_q.push_back('{5'd12, 32'h12});
    step(); idle();
    chk("stv_stall_clr", {31'd0, alu_stall}, 0);
    chk("stv_busy_clr", busy_mask, 0);
    chk("stv_count", {29'd0, fifo_count}, 0);

    // Scoreboard: same-register issue and completion, set wins
    issue(9); done(9, 32'h99); exp_q.push_back('{5'd9, 32'h99});
    step(); idle();
    chk("sb_set_wins", busy_mask, 32'h0000_0200);
    done(0, 32'hFFFF);
    step(); idle();
    chk("sb_addr0_ls", {31'd0, L_S}, 0);
    chk("sb_addr0_count", {29'd0, fifo_count}, 0);
    chk("sb_addr0_busy", busy_mask, 32'h0000_0200);
    done(9, 32'h9A); exp_q.push_back('{5'd9, 32'h9A});
    step(); idle();
    chk("sb_clr", busy_mask, 0);

    // Asynchronous reset mid-stream with three queued entries
    issue(20); step(); idle();
    for (int i = 1; i <= 3; i++) begin
      alu(5'(i), 32'hE000 + i);
      exp_q.push_back('{5'(i), 32'hE000 + i});
      done(5'(20 + i), 32'hF000 + i);
      step();
    end
    chk("rs_count_pre", {29'd0, fifo_count}, 3);
    #2 rst = 0;
    #1;
    chk("rs_count", {29'd0, fifo_count}, 0);
    chk("rs_ls", {31'd0, L_S}, 0);
    chk("rs_busy", busy_mask, 0);
    chk("rs_ready", {31'd0, lq_done_ready}, 1);
    exp_q.delete();
    idle();
    step();
    rst = 1;
    repeat (2) step();
    chk("rs_after_ls", {31'd0, L_S}, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
